// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a WE/DATA/READY handshake.
// Producers write at up to one byte per clock; a four-state drain FSM pops one byte,
// strobes it into the transmitter, then waits for the transmitter to go busy and
// come back ready before it pops the next one. Writes into a full buffer are dropped
// and recorded in a sticky overflow flag.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 WR_EN,
    input  logic [7:0]           WR_DATA,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic                 OVERFLOW,
    input  logic                 CLR_OVF,
    output logic                 TX_WE,
    output logic [7:0]           TX_DATA,
    input  logic                 TX_READY,
    output logic                 BUSY
);

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = DEPTH_LOG;
    localparam int unsigned CW    = DEPTH_LOG + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_BUSY  = 2'd2,
        S_WAIT_READY = 2'd3
    } state_t;

    // storage and bookkeeping registers
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic          r_tx_we;
    logic [DW-1:0] r_tx_data;
    logic          r_busy;
    state_t        r_state;

    // combinational next-state / control
    state_t        w_state_nxt;
    logic          w_wr_acc;
    logic          w_wr_drop;
    logic          w_pop;
    logic [DW-1:0] w_tx_data_nxt;
    logic [CW-1:0] w_count_nxt;

    // write acceptance uses the registered FULL only; a same-edge pop never makes room
    always_comb begin
        w_wr_acc  = 1'b0;
        w_wr_drop = 1'b0;
        if (WR_EN) begin
            if (r_full) begin
                w_wr_drop = 1'b1;
            end else begin
                w_wr_acc = 1'b1;
            end
        end
    end

    // occupancy bookkeeping: +1 on write only, -1 on pop only
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // buffer write port (no reset on the data array)
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    // pointers, count, flags and sticky overflow
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            // a drop on the same edge as a clear keeps the flag set
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end else if (CLR_OVF) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // drain FSM state register
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // drain FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && TX_READY) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!TX_READY) begin
                    w_state_nxt = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (TX_READY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // drain FSM output decode: pop only from IDLE, strobe data follows the pop
    always_comb begin
        w_pop         = 1'b0;
        w_tx_data_nxt = r_tx_data;
        if ((r_state == S_IDLE) && !r_empty && TX_READY) begin
            w_pop         = 1'b1;
            w_tx_data_nxt = r_mem[r_rd_ptr];
        end
    end

    // registered transmitter interface; TX_WE lasts exactly the ISSUE cycle
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_tx_we   <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_tx_we   <= w_pop;
            r_tx_data <= w_tx_data_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign FULL     = r_full;
    assign EMPTY    = r_empty;
    assign COUNT    = r_count;
    assign OVERFLOW = r_overflow;
    assign TX_WE    = r_tx_we;
    assign TX_DATA  = r_tx_data;
    assign BUSY     = r_busy;

endmodule
